// File: rtl/seq_bin2bcd_pkg.sv
// Shared definitions for the display-path binary-to-BCD converter:
// FSM state encoding, default operand/digit sizing and the per-digit adjust rule.
package seq_bin2bcd_pkg;

  localparam int unsigned DEF_WIDTH  = 20;
  localparam int unsigned DEF_DIGITS = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Pre-shift correction so that doubling a digit >= 5 carries into the next digit.
  function automatic logic [3:0] add3_if_ge5(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/seq_bin2bcd_digit_adjust.sv
// Combinational double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_digit_adjust
  import seq_bin2bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = add3_if_ge5(digit_i);
  end

endmodule

// File: rtl/seq_bin2bcd.sv
// Multi-cycle shift-and-add-3 binary-to-BCD engine with start/done handshake,
// overflow detection and a leading-zero blank mask; results hold until the next DONE.
module seq_bin2bcd
  import seq_bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      operand,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  overflow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned BW = 4 * DIGITS;
  localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

  state_e            state_q;
  logic [WIDTH-1:0]  bin_q;
  logic [BW-1:0]     work_q;
  logic              ovf_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q;
  logic              done_q;
  logic [BW-1:0]     bcd_q;
  logic [DIGITS-1:0] blank_q;
  logic              overflow_q;

  logic [BW-1:0]     adj;
  logic [BW-1:0]     work_d;
  logic [WIDTH-1:0]  bin_d;
  logic              ovf_d;
  logic [DIGITS-1:0] blank_d;
  logic              zero_run;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_i (work_q[4*g +: 4]),
      .digit_o (adj[4*g +: 4])
    );
  end

  // The bit shifted out of the top digit is a carry worth 10^DIGITS, so dropping
  // it leaves value mod 10^DIGITS and marks overflow.
  always_comb begin
    work_d = {adj[BW-2:0], bin_q[WIDTH-1]};
    bin_d  = {bin_q[WIDTH-2:0], 1'b0};
    ovf_d  = ovf_q | adj[BW-1];
  end

  // Mask is taken from the post-shift value so it can be registered on the DONE entry edge.
  always_comb begin
    blank_d  = '0;
    zero_run = 1'b1;
    for (int unsigned j = 0; j + 1 < DIGITS; j++) begin
      zero_run = zero_run & (work_d[4*(DIGITS-1-j) +: 4] == 4'd0);
      blank_d[DIGITS-1-j] = zero_run;
    end
    if (ovf_d) begin
      blank_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      work_q     <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      blank_q    <= BLANK_RST;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            bin_q   <= operand;
            work_q  <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          work_q <= work_d;
          bin_q  <= bin_d;
          ovf_q  <= ovf_d;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            bcd_q      <= work_d;
            blank_q    <= blank_d;
            overflow_q <= ovf_d;
            state_q    <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign blank    = blank_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Directed plus random checks of seq_bin2bcd against an arithmetic decimal model.
module tb_seq_bin2bcd;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [19:0] operand;
  logic        busy, done, overflow;
  logic [23:0] bcd;
  logic [5:0]  blank;

  logic        start_s;
  logic [7:0]  operand_s;
  logic        busy_a, done_a, ovf_a;
  logic [11:0] bcd_a;
  logic [2:0]  blank_a;
  logic        busy_b, done_b, ovf_b;
  logic [7:0]  bcd_b;
  logic [1:0]  blank_b;

  int total = 0;
  int bad   = 0;
  bit both_hi = 1'b0;

  always #5 clk = ~clk;

  seq_bin2bcd dut (
    .clk(clk), .reset(reset), .start(start), .operand(operand),
    .busy(busy), .done(done), .bcd(bcd), .blank(blank), .overflow(overflow)
  );

  seq_bin2bcd #(.WIDTH(8), .DIGITS(3)) dut_a (
    .clk(clk), .reset(reset), .start(start_s), .operand(operand_s),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .blank(blank_a), .overflow(ovf_a)
  );

  seq_bin2bcd #(.WIDTH(8), .DIGITS(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_s), .operand(operand_s),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .blank(blank_b), .overflow(ovf_b)
  );

  always @(negedge clk) begin
    if ((busy && done) || (busy_a && done_a) || (busy_b && done_b)) both_hi = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic longint pow10(input int d);
    longint p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [23:0] m_bcd(input longint v, input int d);
    logic [23:0] r = '0;
    longint m = v % pow10(d);
    for (int i = 0; i < d; i++) r[4*i +: 4] = 4'((m / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [5:0] m_blank(input longint v, input int d);
    logic [5:0] r = '0;
    if (v >= pow10(d)) return r;
    for (int i = 1; i < d; i++) r[i] = (v < pow10(i));
    return r;
  endfunction

  function automatic logic m_ovf(input longint v, input int d);
    return v >= pow10(d);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [19:0] v);
    start   = 1'b1;
    operand = v;
    @(posedge clk); #1;
    start   = 1'b0;
    operand = 20'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_result(input string tag, input longint v);
    check({tag, "_bcd"},   64'(bcd),      64'(m_bcd(v, 6)));
    check({tag, "_blank"}, 64'(blank),    64'(m_blank(v, 6)));
    check({tag, "_ovf"},   64'(overflow), 64'(m_ovf(v, 6)));
  endtask

  task automatic convert(input string tag, input longint v);
    int n;
    do_start(20'(v));
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(n);
    check({tag, "_lat"}, 64'(n), 64'd20);
    check_result(tag, v);
    @(posedge clk); #1;
    check({tag, "_hold"}, {39'd0, done, bcd}, {40'd0, m_bcd(v, 6)});
  endtask

  task automatic conv_small(input string tag, input int unsigned v);
    int n = 0;
    start_s   = 1'b1;
    operand_s = 8'(v);
    @(posedge clk); #1;
    start_s   = 1'b0;
    while (done_a !== 1'b1 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"},    64'(n),      64'd8);
    check({tag, "_doneb"},  64'(done_b), 64'd1);
    check({tag, "_bcd3"},   64'(bcd_a),  64'(m_bcd(v, 3)));
    check({tag, "_blank3"}, 64'(blank_a), 64'(m_blank(v, 3)));
    check({tag, "_ovf3"},   64'(ovf_a),  64'(m_ovf(v, 3)));
    check({tag, "_bcd2"},   64'(bcd_b),  64'(m_bcd(v, 2)));
    check({tag, "_blank2"}, 64'(blank_b), 64'(m_blank(v, 2)));
    check({tag, "_ovf2"},   64'(ovf_b),  64'(m_ovf(v, 2)));
  endtask

  initial begin
    int n;
    int k;
    bit held;
    bit saw_done;
    longint v;

    reset = 1'b1; start = 1'b0; operand = '0; start_s = 1'b0; operand_s = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_main", {busy, done, overflow, blank, bcd}, {3'b000, 6'b111110, 24'h0});
    check("rst_a", {busy_a, done_a, ovf_a, blank_a, bcd_a}, {3'b000, 3'b110, 12'h0});
    check("rst_b", {busy_b, done_b, ovf_b, blank_b, bcd_b}, {3'b000, 2'b10, 8'h0});
    reset = 1'b0;
    @(posedge clk); #1;

    convert("v23", 23);
    convert("v999999", 999999);
    convert("v0", 0);
    convert("v1048575", 1048575);
    convert("v1000000", 1000000);

    for (int i = 0; i < 8; i++) begin
      v = (i % 2 == 0) ? longint'($urandom_range(0, 999999)) : longint'($urandom_range(0, 1048575));
      convert("rand", v);
    end

    // start during SHIFT is ignored
    do_start(20'd4321);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; operand = 20'd55;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    check("ign_lat", 64'(n), 64'd15);
    check_result("ign", 4321);

    // reset in mid-conversion aborts without done and clears outputs
    do_start(20'd777);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_state", {busy, done, overflow, blank, bcd}, {3'b000, 6'b111110, 24'h0});
    saw_done = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("abort_nodone", 64'(saw_done), 64'd0);
    convert("v777", 777);

    // back-to-back with start held across DONE
    start = 1'b1; operand = 20'd12;
    @(posedge clk); #1;
    operand = 20'd34;
    wait_done(n);
    check("b2b_lat1", 64'(n), 64'd20);
    check("b2b_bcd1", 64'(bcd), 64'h12);
    @(posedge clk); #1;
    start = 1'b0;
    k = 1;
    held = 1'b1;
    while (done !== 1'b1 && k < 60) begin
      if (bcd !== 24'h000012) held = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    check("b2b_hold12", 64'(held), 64'd1);
    check("b2b_gap", 64'(k), 64'd21);
    check_result("b2b2", 34);

    conv_small("s255", 255);
    conv_small("s200", 200);
    conv_small("s99", 99);
    conv_small("s100", 100);
    conv_small("s0", 0);
    for (int i = 0; i < 4; i++) conv_small("srand", $urandom_range(0, 255));

    check("busy_done_excl", 64'(both_hi), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
